ball_motion: RTL and testbench

Per-game ball kinematics and win/lose sequencer for the balance-board game. Sits directly downstream of the map lookup: on `start` it latches the current map's ball start point (`init_x/init_y`) and goal point (`score_x/score_y`). On every frame tick it integrates the board tilt into velocity and position, clamps the ball at the board walls, and decides WIN (ball held in the goal zone) or LOSE (time limit). Its ball position feeds the VGA renderer; its status feeds the score/display logic.

---
 rtl/ball_motion.sv | 160 ++++++++++++++++
 tb/tb_ball_motion.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball kinematics and win/lose sequencer: integrates board tilt into velocity and
// position each frame, clamps at the walls and decides WIN (goal held) or LOSE (time out).
//
// state  | meaning
// IDLE   | after reset, waiting for start; frame ticks ignored
// RUN    | game in progress, every frame tick updates the ball
// WIN    | ball held in goal zone long enough; everything frozen
// LOSE   | time limit reached; everything frozen
module ball_motion #(
  parameter int BOARD_W     = 640,
  parameter int BOARD_H     = 480,
  parameter int RADIUS      = 8,
  parameter int VMAX        = 255,
  parameter int VSHIFT      = 4,
  parameter int WIN_R       = 16,
  parameter int HOLD_FRAMES = 30,
  parameter int TIME_LIMIT  = 3600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              start,
  input  logic signed [7:0] tilt_x,
  input  logic signed [7:0] tilt_y,
  input  logic [10:0]       init_x,
  input  logic [10:0]       init_y,
  input  logic [10:0]       score_x,
  input  logic [10:0]       score_y,
  output logic [10:0]       ball_x,
  output logic [10:0]       ball_y,
  output logic [1:0]        state,
  output logic [11:0]       frames,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  localparam logic signed [12:0] VMAX_S = 13'(VMAX);
  localparam logic signed [12:0] LO_S   = 13'(RADIUS);
  localparam logic signed [12:0] HI_X_S = 13'(BOARD_W - 1 - RADIUS);
  localparam logic signed [12:0] HI_Y_S = 13'(BOARD_H - 1 - RADIUS);
  localparam logic signed [11:0] WIN_S  = 12'(WIN_R);
  localparam logic [11:0]        HOLD_N = 12'(HOLD_FRAMES);
  localparam logic [11:0]        TL_N   = 12'(TIME_LIMIT);

  state_e             state_q, state_d;
  logic [10:0]        bx_q, bx_d, by_q, by_d;
  logic signed [12:0] vx_q, vx_d, vy_q, vy_d;
  logic [10:0]        gx_q, gx_d, gy_q, gy_d;
  logic [11:0]        frames_q, frames_d;
  logic [11:0]        hold_q, hold_d;
  logic               done_q, done_d;
  logic [23:0]        step_x, step_y;
  logic               in_zone;

  // One axis of the frame update; returns {position, velocity}.
  function automatic logic [23:0] axis_step(input logic [10:0]        p,
                                            input logic signed [12:0] v,
                                            input logic signed [7:0]  t,
                                            input logic signed [12:0] hi);
    logic signed [12:0] vs;
    logic signed [12:0] vc;
    logic signed [12:0] pn;
    vs = v + $signed({{5{t[7]}}, t});
    if (vs > VMAX_S)       vc = VMAX_S;
    else if (vs < -VMAX_S) vc = -VMAX_S;
    else                   vc = vs;
    pn = $signed({2'b00, p}) + (vc >>> VSHIFT);
    if (pn < LO_S)      return {LO_S[10:0], 13'sd0};
    else if (pn > hi)   return {hi[10:0], 13'sd0};
    else                return {pn[10:0], vc};
  endfunction

  function automatic logic near(input logic [10:0] a, input logic [10:0] b);
    logic signed [11:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= WIN_S;
  endfunction

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    frames_d = frames_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    in_zone  = 1'b0;
    step_x   = axis_step(bx_q, vx_q, tilt_x, HI_X_S);
    step_y   = axis_step(by_q, vy_q, tilt_y, HI_Y_S);

    // start wins over a coincident tick, which is simply dropped
    if (start) begin
      state_d  = S_RUN;
      bx_d     = init_x;
      by_d     = init_y;
      vx_d     = '0;
      vy_d     = '0;
      gx_d     = score_x;
      gy_d     = score_y;
      frames_d = '0;
      hold_d   = '0;
    end else if (frame_tick && state_q == S_RUN) begin
      {bx_d, vx_d} = step_x;
      {by_d, vy_d} = step_y;
      frames_d     = frames_q + 12'd1;
      in_zone      = near(bx_d, gx_q) && near(by_d, gy_q);
      hold_d       = in_zone ? hold_q + 12'd1 : 12'd0;
      if (in_zone && hold_d == HOLD_N) begin
        state_d = S_WIN;
        done_d  = 1'b1;
      end else if (frames_d == TL_N) begin
        state_d = S_LOSE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      frames_q <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      frames_q <= frames_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
    end
  end

  assign ball_x = bx_q;
  assign ball_y = by_q;
  assign state  = state_q;
  assign frames = frames_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed scenarios plus randomized games checked against an
// integer reference model; a second instance runs with short time/hold limits.
module tb_ball_motion;

  localparam int BW = 640;
  localparam int BH = 480;
  localparam int R  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_tick = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] tilt_x = '0;
  logic signed [7:0] tilt_y = '0;
  logic [10:0]       init_x = '0, init_y = '0, score_x = '0, score_y = '0;

  logic [10:0] bx0, by0, bx1, by1;
  logic [1:0]  st0, st1;
  logic [11:0] fr0, fr1;
  logic        dn0, dn1;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model, index 0 = default instance, 1 = short-limit instance
  int m_st[2], m_x[2], m_y[2], m_vx[2], m_vy[2], m_fr[2], m_hold[2], m_gx[2], m_gy[2], m_dn[2];
  int tl[2] = '{3600, 10};
  int hf[2] = '{30, 10};

  ball_motion dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .tilt_x(tilt_x), .tilt_y(tilt_y), .init_x(init_x), .init_y(init_y),
    .score_x(score_x), .score_y(score_y),
    .ball_x(bx0), .ball_y(by0), .state(st0), .frames(fr0), .done(dn0)
  );

  ball_motion #(.TIME_LIMIT(10), .HOLD_FRAMES(10)) dut_tl (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .tilt_x(tilt_x), .tilt_y(tilt_y), .init_x(init_x), .init_y(init_y),
    .score_x(score_x), .score_y(score_y),
    .ball_x(bx1), .ball_y(by1), .state(st1), .frames(fr1), .done(dn1)
  );

  always #5 clk = ~clk;

  function automatic int floor_div16(input int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_axis(input int p, input int v, input int t, input int board,
                            output int np, output int nv);
    int vs, q;
    vs = v + t;
    if (vs > 255)  vs = 255;
    if (vs < -255) vs = -255;
    q = p + floor_div16(vs);
    if (q < R)               begin np = R;             nv = 0;  end
    else if (q > board-1-R)  begin np = board - 1 - R; nv = 0;  end
    else                     begin np = q;             nv = vs; end
  endtask

  task automatic model_apply();
    int nx, ny, nvx, nvy;
    for (int k = 0; k < 2; k++) begin
      m_dn[k] = 0;
      if (!rst) begin
        m_st[k] = 0; m_x[k] = 0; m_y[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
        m_fr[k] = 0; m_hold[k] = 0; m_gx[k] = 0; m_gy[k] = 0;
      end else if (start) begin
        m_st[k] = 1; m_x[k] = int'(init_x); m_y[k] = int'(init_y);
        m_vx[k] = 0; m_vy[k] = 0; m_fr[k] = 0; m_hold[k] = 0;
        m_gx[k] = int'(score_x); m_gy[k] = int'(score_y);
      end else if (frame_tick && m_st[k] == 1) begin
        model_axis(m_x[k], m_vx[k], int'(tilt_x), BW, nx, nvx);
        model_axis(m_y[k], m_vy[k], int'(tilt_y), BH, ny, nvy);
        m_x[k] = nx; m_vx[k] = nvx; m_y[k] = ny; m_vy[k] = nvy;
        m_fr[k]++;
        if (iabs(m_x[k] - m_gx[k]) <= 16 && iabs(m_y[k] - m_gy[k]) <= 16) m_hold[k]++;
        else m_hold[k] = 0;
        if (m_hold[k] == hf[k])      begin m_st[k] = 2; m_dn[k] = 1; end
        else if (m_fr[k] == tl[k])   begin m_st[k] = 3; m_dn[k] = 1; end
      end
    end
  endtask

  task automatic step(input bit s, input bit t);
    start = s;
    frame_tick = t;
    @(posedge clk);
    model_apply();
    #1;
    start = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_checks++;
    if (st0 !== 2'd0 || bx0 !== 11'd0 || by0 !== 11'd0 || fr0 !== 12'd0 || dn0 !== 1'b0)
      $display("FAIL reset_dut0 got st=%0d x=%0d y=%0d fr=%0d dn=%0d want all 0", st0, bx0, by0, fr0, dn0);
    else n_pass++;
    n_checks++;
    if (st1 !== 2'd0 || bx1 !== 11'd0 || by1 !== 11'd0 || fr1 !== 12'd0 || dn1 !== 1'b0)
      $display("FAIL reset_dut1 got st=%0d x=%0d y=%0d fr=%0d dn=%0d want all 0", st1, bx1, by1, fr1, dn1);
    else n_pass++;
    rst = 1'b1;
    tilt_x = 8'sd50;
    step(1'b0, 1'b1);
    n_checks++;
    if (st0 !== 2'd0 || bx0 !== 11'd0 || fr0 !== 12'd0)
      $display("FAIL idle_tick got st=%0d x=%0d fr=%0d want 0 0 0", st0, bx0, fr0);
    else n_pass++;
    tilt_x = 8'sd0;
  endtask

  task automatic test_start();
    init_x = 11'd60; init_y = 11'd60; score_x = 11'd240; score_y = 11'd240;
    step(1'b1, 1'b0);
    n_checks++;
    if (bx0 !== 11'd60 || by0 !== 11'd60) $display("FAIL start_ball got (%0d,%0d) want (60,60)", bx0, by0);
    else n_pass++;
    n_checks++;
    if (st0 !== 2'd1 || fr0 !== 12'd0 || dn0 !== 1'b0)
      $display("FAIL start_state got st=%0d fr=%0d dn=%0d want 1 0 0", st0, fr0, dn0);
    else n_pass++;
  endtask

  task automatic test_accel();
    tilt_x = 8'sd16;
    step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd61 || by0 !== 11'd60 || fr0 !== 12'd1)
      $display("FAIL accel_pos got (%0d,%0d) fr=%0d want (61,60) fr=1", bx0, by0, fr0);
    else n_pass++;
    init_x = 11'd500; score_x = 11'd60; score_y = 11'd60;
    tilt_x = -8'sd32;
    step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd60 || fr0 !== 12'd2 || st0 !== 2'd1)
      $display("FAIL decel_pos got x=%0d fr=%0d st=%0d want x=60 fr=2 st=1", bx0, fr0, st0);
    else n_pass++;
    tilt_x = 8'sd0;
  endtask

  task automatic test_walls();
    init_x = 11'd600; init_y = 11'd240; score_x = 11'd60; score_y = 11'd60;
    step(1'b1, 1'b0);
    tilt_x = 8'sd127;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      n_checks++;
      if (bx0 !== 11'(m_x[0]) || by0 !== 11'(m_y[0]))
        $display("FAIL right_wall_step%0d got (%0d,%0d) want (%0d,%0d)", i, bx0, by0, m_x[0], m_y[0]);
      else n_pass++;
    end
    n_checks++;
    if (bx0 !== 11'd631) $display("FAIL right_wall_clamp got %0d want 631", bx0);
    else n_pass++;
    init_x = 11'd40;
    step(1'b1, 1'b0);
    tilt_x = -8'sd128;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd8) $display("FAIL left_wall_clamp got %0d want 8", bx0);
    else n_pass++;
    tilt_x = 8'sd0;
    step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd8) $display("FAIL left_wall_vel_zero got %0d want 8", bx0);
    else n_pass++;
  endtask

  task automatic test_win();
    int d0, d1;
    d0 = 0; d1 = 0;
    init_x = 11'd240; init_y = 11'd240; score_x = 11'd240; score_y = 11'd240;
    tilt_x = 8'sd0; tilt_y = 8'sd0;
    step(1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1);
      d0 += int'(dn0);
      d1 += int'(dn1);
      n_checks++;
      if (st0 !== ((i < 30) ? 2'd1 : 2'd2)) $display("FAIL win_state tick%0d got %0d", i, st0);
      else n_pass++;
      if (i == 10) begin
        n_checks++;
        if (st1 !== 2'd2 || fr1 !== 12'd10)
          $display("FAIL win_over_timeout got st=%0d fr=%0d want st=2 fr=10", st1, fr1);
        else n_pass++;
      end
    end
    n_checks++;
    if (d0 != 1 || d1 != 1) $display("FAIL win_done_count got %0d/%0d want 1/1", d0, d1);
    else n_pass++;
    tilt_x = 8'sd100;
    step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd240 || by0 !== 11'd240 || fr0 !== 12'd30 || st0 !== 2'd2 || dn0 !== 1'b0)
      $display("FAIL win_frozen got x=%0d y=%0d fr=%0d st=%0d dn=%0d want 240 240 30 2 0",
               bx0, by0, fr0, st0, dn0);
    else n_pass++;
    tilt_x = 8'sd0;
  endtask

  task automatic test_lose();
    int d1;
    d1 = 0;
    init_x = 11'd60; init_y = 11'd60; score_x = 11'd400; score_y = 11'd400;
    step(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      d1 += int'(dn1);
      if (i == 9) begin
        n_checks++;
        if (st1 !== 2'd1) $display("FAIL lose_early got st=%0d want 1", st1);
        else n_pass++;
      end
    end
    n_checks++;
    if (st1 !== 2'd3 || fr1 !== 12'd10 || d1 != 1)
      $display("FAIL lose_timeout got st=%0d fr=%0d dones=%0d want 3 10 1", st1, fr1, d1);
    else n_pass++;
    n_checks++;
    if (st0 !== 2'd1 || fr0 !== 12'd10) $display("FAIL lose_long_limit got st=%0d fr=%0d want 1 10", st0, fr0);
    else n_pass++;
  endtask

  task automatic test_start_tick_collision();
    init_x = 11'd100; init_y = 11'd100; score_x = 11'd400; score_y = 11'd400;
    step(1'b1, 1'b0);
    tilt_x = 8'sd50; tilt_y = -8'sd30;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    init_x = 11'd300; init_y = 11'd200;
    step(1'b1, 1'b1);
    n_checks++;
    if (bx0 !== 11'd300 || by0 !== 11'd200 || fr0 !== 12'd0 || st0 !== 2'd1)
      $display("FAIL start_tick got (%0d,%0d) fr=%0d st=%0d want (300,200) 0 1", bx0, by0, fr0, st0);
    else n_pass++;
    tilt_x = 8'sd0; tilt_y = 8'sd0;
    step(1'b0, 1'b1);
    n_checks++;
    if (bx0 !== 11'd300 || by0 !== 11'd200 || fr0 !== 12'd1)
      $display("FAIL restart_vel_clear got (%0d,%0d) fr=%0d want (300,200) 1", bx0, by0, fr0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    tilt_x = 8'sd40;
    step(1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b1);
    n_checks++;
    if (st0 !== 2'd0 || bx0 !== 11'd0 || by0 !== 11'd0 || fr0 !== 12'd0 || dn0 !== 1'b0)
      $display("FAIL reset_mid_run got st=%0d (%0d,%0d) fr=%0d dn=%0d want 0 (0,0) 0 0", st0, bx0, by0, fr0, dn0);
    else n_pass++;
    rst = 1'b1;
    tilt_x = 8'sd0;
  endtask

  task automatic test_random();
    logic [10:0] ax, ay;
    logic [1:0]  as;
    logic [11:0] af;
    logic        ad;
    int t, span;
    for (int g = 0; g < 6; g++) begin
      init_x = 11'($urandom_range(R, BW - 1 - R));
      init_y = 11'($urandom_range(R, BH - 1 - R));
      if (g % 2 == 0) begin
        score_x = 11'(int'(init_x) + int'($urandom_range(0, 20)) - 10);
        score_y = 11'(int'(init_y) + int'($urandom_range(0, 20)) - 10);
        span = 2;
      end else begin
        score_x = 11'($urandom_range(0, BW - 1));
        score_y = 11'($urandom_range(0, BH - 1));
        span = (g == 5) ? 127 : 40;
      end
      step(1'b1, 1'b0);
      for (int c = 0; c < 120; c++) begin
        t = int'($urandom_range(0, 2 * span)) - span;
        tilt_x = t[7:0];
        t = int'($urandom_range(0, 2 * span)) - span;
        tilt_y = t[7:0];
        if ($urandom_range(0, 19) == 0) init_x = 11'($urandom_range(R, BW - 1 - R));
        if ($urandom_range(0, 19) == 0) score_x = 11'($urandom_range(0, BW - 1));
        step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7);
        for (int k = 0; k < 2; k++) begin
          ax = k ? bx1 : bx0;  ay = k ? by1 : by0;  as = k ? st1 : st0;
          af = k ? fr1 : fr0;  ad = k ? dn1 : dn0;
          n_checks++;
          if (ax !== 11'(m_x[k]) || ay !== 11'(m_y[k]) || as !== 2'(m_st[k]) ||
              af !== 12'(m_fr[k]) || ad !== 1'(m_dn[k]))
            $display("FAIL rand_g%0d_c%0d_dut%0d got x=%0d y=%0d st=%0d fr=%0d dn=%0d want x=%0d y=%0d st=%0d fr=%0d dn=%0d",
                     g, c, k, ax, ay, as, af, ad, m_x[k], m_y[k], m_st[k], m_fr[k], m_dn[k]);
          else n_pass++;
        end
      end
    end
    tilt_x = 8'sd0;
    tilt_y = 8'sd0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_x[k] = 0; m_y[k] = 0; m_vx[k] = 0; m_vy[k] = 0;
      m_fr[k] = 0; m_hold[k] = 0; m_gx[k] = 0; m_gy[k] = 0; m_dn[k] = 0;
    end
    test_reset();
    test_start();
    test_accel();
    test_walls();
    test_win();
    test_lose();
    test_start_tick_collision();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
